// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch block.
// Optional build macro: STOPWATCH_HR_WRAP_EN (hour rollover wraps instead of saturating).
`timescale 1ns/1ps

package stopwatch_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    typedef enum logic {
        LIVE = 1'b0,
        LAP  = 1'b1
    } disp_mode_t;

    // Millisecond counter width; never below one bit so MS_PER_SEC=1 still builds.
    function automatic int ms_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Front-panel / display bundle between the panel logic and the stopwatch.
// master drives buttons and timebase, slave (the stopwatch) drives the display fields.
`timescale 1ns/1ps

interface stopwatch_if;
    import stopwatch_pkg::*;

    logic             i_set;
    logic             i_up;
    logic             i_down;
    logic             i_right;
    logic             i_left;
    logic             i_ms_pulse;
    logic [SEC_W-1:0] o_sec;
    logic [MIN_W-1:0] o_min;
    logic [HR_W-1:0]  o_hr;

    modport master (
        output i_set, i_up, i_down, i_right, i_left, i_ms_pulse,
        input  o_sec, o_min, o_hr
    );

    modport slave (
        input  i_set, i_up, i_down, i_right, i_left, i_ms_pulse,
        output o_sec, o_min, o_hr
    );
endinterface

// File: rtl/stopwatch_edge_det.sv
// Single-bit rising-edge detector: one pulse per low-to-high transition,
// so a held button or a wide timebase strobe produces exactly one action.
`timescale 1ns/1ps

module stopwatch_edge_det (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_rise
);
    logic r_prev;

    // Remember last sample of the input.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_prev <= 1'b0;
        else         r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/stopwatch_unit.sv
// Elapsed-time stopwatch: ms ticks -> sec/min/hr with run/pause, clear and lap freeze.
// Optional build macro: STOPWATCH_HR_WRAP_EN
//   defined     : 23:59:59.(MS_PER_SEC-1) + tick wraps to zero and keeps running
//   not defined : time saturates there and the run FSM drops to PAUSED
//
//   state   | meaning
//   --------+--------------------------------------------------
//   PAUSED  | counters frozen; clear (down) is honoured
//   RUNNING | counters advance on each ms edge; clear ignored
`timescale 1ns/1ps

module stopwatch_unit
    import stopwatch_pkg::*;
#(
    parameter int MS_PER_SEC = 1000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    stopwatch_if.slave sw_if
);
    localparam int             MS_W    = ms_width(MS_PER_SEC);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);

    logic w_up_rise, w_down_rise, w_right_rise, w_left_rise, w_ms_rise;
    logic w_up_e, w_down_e, w_right_e, w_left_e;

    run_state_t       r_state, w_nxt_state;
    disp_mode_t       r_mode,  w_nxt_mode;
    logic [MS_W-1:0]  r_ms,    w_nxt_ms;
    logic [SEC_W-1:0] r_sec,   w_nxt_sec;
    logic [MIN_W-1:0] r_min,   w_nxt_min;
    logic [HR_W-1:0]  r_hr,    w_nxt_hr;
    logic [SEC_W-1:0] r_snap_sec, w_nxt_snap_sec;
    logic [MIN_W-1:0] r_snap_min, w_nxt_snap_min;
    logic [HR_W-1:0]  r_snap_hr,  w_nxt_snap_hr;
    logic [SEC_W-1:0] r_o_sec;
    logic [MIN_W-1:0] r_o_min;
    logic [HR_W-1:0]  r_o_hr;
    logic             w_tick, w_at_max, w_sat_hit;

    stopwatch_edge_det u_ed_up    (.i_clk(i_clk), .i_rstn(i_rstn), .i_d(sw_if.i_up),       .o_rise(w_up_rise));
    stopwatch_edge_det u_ed_down  (.i_clk(i_clk), .i_rstn(i_rstn), .i_d(sw_if.i_down),     .o_rise(w_down_rise));
    stopwatch_edge_det u_ed_right (.i_clk(i_clk), .i_rstn(i_rstn), .i_d(sw_if.i_right),    .o_rise(w_right_rise));
    stopwatch_edge_det u_ed_left  (.i_clk(i_clk), .i_rstn(i_rstn), .i_d(sw_if.i_left),     .o_rise(w_left_rise));
    stopwatch_edge_det u_ed_ms    (.i_clk(i_clk), .i_rstn(i_rstn), .i_d(sw_if.i_ms_pulse), .o_rise(w_ms_rise));

    // Set mode owns the panel: button edges are dropped, not deferred.
    assign w_up_e    = w_up_rise    & ~sw_if.i_set;
    assign w_down_e  = w_down_rise  & ~sw_if.i_set;
    assign w_right_e = w_right_rise & ~sw_if.i_set;
    assign w_left_e  = w_left_rise  & ~sw_if.i_set;

    // Ticks and clear both look at the pre-toggle state.
    assign w_tick   = w_ms_rise && (r_state == RUNNING);
    assign w_at_max = (r_ms == MS_LAST) && (r_sec == SEC_MAX) &&
                      (r_min == MIN_MAX) && (r_hr == HR_MAX);

    // Next-state for counters, run FSM, lap snapshot and display mode.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_mode     = r_mode;
        w_nxt_ms       = r_ms;
        w_nxt_sec      = r_sec;
        w_nxt_min      = r_min;
        w_nxt_hr       = r_hr;
        w_nxt_snap_sec = r_snap_sec;
        w_nxt_snap_min = r_snap_min;
        w_nxt_snap_hr  = r_snap_hr;
        w_sat_hit      = 1'b0;

        if (w_tick) begin
            if (w_at_max) begin
`ifdef STOPWATCH_HR_WRAP_EN
                w_nxt_ms  = '0;
                w_nxt_sec = '0;
                w_nxt_min = '0;
                w_nxt_hr  = '0;
`else
                w_sat_hit = 1'b1;
`endif
            end else if (r_ms == MS_LAST) begin
                w_nxt_ms = '0;
                if (r_sec == SEC_MAX) begin
                    w_nxt_sec = '0;
                    if (r_min == MIN_MAX) begin
                        w_nxt_min = '0;
                        w_nxt_hr  = r_hr + 1'b1;
                    end else begin
                        w_nxt_min = r_min + 1'b1;
                    end
                end else begin
                    w_nxt_sec = r_sec + 1'b1;
                end
            end else begin
                w_nxt_ms = r_ms + 1'b1;
            end
        end

        // Release wins over capture when both arrive together.
        if (w_left_e) begin
            w_nxt_mode = LIVE;
        end else if (w_right_e) begin
            w_nxt_mode     = LAP;
            w_nxt_snap_sec = r_sec;
            w_nxt_snap_min = r_min;
            w_nxt_snap_hr  = r_hr;
        end

        if (w_down_e && (r_state == PAUSED)) begin
            w_nxt_ms   = '0;
            w_nxt_sec  = '0;
            w_nxt_min  = '0;
            w_nxt_hr   = '0;
            w_nxt_mode = LIVE;
        end

        if (w_up_e) begin
            w_nxt_state = (r_state == PAUSED) ? RUNNING : PAUSED;
        end

        // Hitting the ceiling stops the watch; only a clear gets it moving again.
        if (w_sat_hit) begin
            w_nxt_state = PAUSED;
        end
    end

    // State registers plus display outputs taken from next-state, so every
    // action shows up one clock after its edge is sampled.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= PAUSED;
            r_mode     <= LIVE;
            r_ms       <= '0;
            r_sec      <= '0;
            r_min      <= '0;
            r_hr       <= '0;
            r_snap_sec <= '0;
            r_snap_min <= '0;
            r_snap_hr  <= '0;
            r_o_sec    <= '0;
            r_o_min    <= '0;
            r_o_hr     <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_mode     <= w_nxt_mode;
            r_ms       <= w_nxt_ms;
            r_sec      <= w_nxt_sec;
            r_min      <= w_nxt_min;
            r_hr       <= w_nxt_hr;
            r_snap_sec <= w_nxt_snap_sec;
            r_snap_min <= w_nxt_snap_min;
            r_snap_hr  <= w_nxt_snap_hr;
            r_o_sec    <= (w_nxt_mode == LAP) ? w_nxt_snap_sec : w_nxt_sec;
            r_o_min    <= (w_nxt_mode == LAP) ? w_nxt_snap_min : w_nxt_min;
            r_o_hr     <= (w_nxt_mode == LAP) ? w_nxt_snap_hr  : w_nxt_hr;
        end
    end

    assign sw_if.o_sec = r_o_sec;
    assign sw_if.o_min = r_o_min;
    assign sw_if.o_hr  = r_o_hr;
endmodule

// File: tb/tb_stopwatch_unit.sv
// Directed bench for stopwatch_unit, run with a short second (MS_PER_SEC=4).
// Expected display values are hand-derived for each scenario.
`timescale 1ns/1ps

module tb_stopwatch_unit;
    localparam int MS = 4;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    stopwatch_if sw();

    stopwatch_unit #(.MS_PER_SEC(MS)) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .sw_if (sw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    function automatic logic [16:0] cur();
        return {sw.o_hr, sw.o_min, sw.o_sec};
    endfunction

    task automatic do_tick();
        @(negedge clk) sw.i_ms_pulse = 1'b1;
        @(negedge clk) sw.i_ms_pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic press(input logic up, input logic dn, input logic rt, input logic lf);
        @(negedge clk);
        sw.i_up = up; sw.i_down = dn; sw.i_right = rt; sw.i_left = lf;
        @(negedge clk);
        sw.i_up = 1'b0; sw.i_down = 1'b0; sw.i_right = 1'b0; sw.i_left = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        sw.i_set = 1'b0; sw.i_up = 1'b0; sw.i_down = 1'b0;
        sw.i_right = 1'b0; sw.i_left = 1'b0; sw.i_ms_pulse = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL reset: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        ticks(3000);
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL idle_paused: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
    endtask

    task automatic test_count();
        press(1, 0, 0, 0);
        ticks(61 * MS);
        n_checks++;
        if (cur() !== hms(0, 1, 1)) begin
            n_errors++;
            $display("FAIL count_61s: got %0d:%0d:%0d want 0:1:1", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 1, 0, 0);
        n_checks++;
        if (cur() !== hms(0, 1, 1)) begin
            n_errors++;
            $display("FAIL down_while_running: got %0d:%0d:%0d want 0:1:1", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(MS - 1);
        n_checks++;
        if (cur() !== hms(0, 1, 1)) begin
            n_errors++;
            $display("FAIL ms_below_boundary: got %0d:%0d:%0d want 0:1:1", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(1);
        n_checks++;
        if (cur() !== hms(0, 1, 2)) begin
            n_errors++;
            $display("FAIL ms_boundary: got %0d:%0d:%0d want 0:1:2", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL clear_paused: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
    endtask

    task automatic test_lap();
        press(1, 0, 0, 0);
        ticks(5 * MS);
        press(0, 0, 1, 0);
        n_checks++;
        if (cur() !== hms(0, 0, 5)) begin
            n_errors++;
            $display("FAIL lap_capture: got %0d:%0d:%0d want 0:0:5", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(2 * MS);
        n_checks++;
        if (cur() !== hms(0, 0, 5)) begin
            n_errors++;
            $display("FAIL lap_frozen: got %0d:%0d:%0d want 0:0:5", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 0, 0, 1);
        n_checks++;
        if (cur() !== hms(0, 0, 7)) begin
            n_errors++;
            $display("FAIL lap_release: got %0d:%0d:%0d want 0:0:7", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(2 * MS);
    endtask

    task automatic test_pause();
        press(1, 0, 0, 0);
        ticks(5 * MS);
        n_checks++;
        if (cur() !== hms(0, 0, 9)) begin
            n_errors++;
            $display("FAIL pause_hold: got %0d:%0d:%0d want 0:0:9", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 1, 0, 0);
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL pause_clear: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(1, 0, 0, 0);
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 1)) begin
            n_errors++;
            $display("FAIL resume_from_zero: got %0d:%0d:%0d want 0:0:1", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 0, 1, 0);
        ticks(MS);
        press(0, 0, 1, 0);
        n_checks++;
        if (cur() !== hms(0, 0, 2)) begin
            n_errors++;
            $display("FAIL lap_recapture: got %0d:%0d:%0d want 0:0:2", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 0, 0, 1);
    endtask

    task automatic test_set();
        sw.i_set = 1'b1;
        press(1, 0, 0, 0);
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 3)) begin
            n_errors++;
            $display("FAIL set_up_ignored: got %0d:%0d:%0d want 0:0:3", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 0, 1, 0);
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 4)) begin
            n_errors++;
            $display("FAIL set_right_ignored: got %0d:%0d:%0d want 0:0:4", sw.o_hr, sw.o_min, sw.o_sec);
        end
        sw.i_set = 1'b0;
        press(1, 0, 0, 0);
        sw.i_set = 1'b1;
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 4)) begin
            n_errors++;
            $display("FAIL set_down_up_ignored: got %0d:%0d:%0d want 0:0:4", sw.o_hr, sw.o_min, sw.o_sec);
        end
        sw.i_set = 1'b0;
        press(1, 0, 0, 0);
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 5)) begin
            n_errors++;
            $display("FAIL set_released_toggle: got %0d:%0d:%0d want 0:0:5", sw.o_hr, sw.o_min, sw.o_sec);
        end
    endtask

    task automatic test_simultaneous();
        press(1, 0, 0, 0);
        press(1, 1, 0, 0);
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL up_down_clear: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 1)) begin
            n_errors++;
            $display("FAIL up_down_running: got %0d:%0d:%0d want 0:0:1", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 0, 1, 1);
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 2)) begin
            n_errors++;
            $display("FAIL left_beats_right: got %0d:%0d:%0d want 0:0:2", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(MS - 1);
        @(negedge clk);
        sw.i_ms_pulse = 1'b1; sw.i_up = 1'b1;
        @(negedge clk);
        sw.i_ms_pulse = 1'b0; sw.i_up = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cur() !== hms(0, 0, 3)) begin
            n_errors++;
            $display("FAIL tick_with_up: got %0d:%0d:%0d want 0:0:3", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 3)) begin
            n_errors++;
            $display("FAIL paused_after_tick_up: got %0d:%0d:%0d want 0:0:3", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(1, 0, 0, 0);
        ticks(MS - 1);
        @(negedge clk) sw.i_ms_pulse = 1'b1;
        repeat (5) @(negedge clk);
        sw.i_ms_pulse = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cur() !== hms(0, 0, 4)) begin
            n_errors++;
            $display("FAIL wide_ms_pulse: got %0d:%0d:%0d want 0:0:4", sw.o_hr, sw.o_min, sw.o_sec);
        end
    endtask

    task automatic test_reset_midrun();
        ticks(MS);
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL async_reset: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
        @(negedge clk) rstn = 1'b1;
        ticks(MS);
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL reset_paused: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
    endtask

    task automatic test_rollover();
        @(negedge clk);
        force dut.r_hr  = 5'd23;
        force dut.r_min = 6'd59;
        force dut.r_sec = 6'd59;
        force dut.r_ms  = 2'(MS - 2);
        repeat (2) @(negedge clk);
        release dut.r_hr;
        release dut.r_min;
        release dut.r_sec;
        release dut.r_ms;
        @(negedge clk);
        press(1, 0, 0, 0);
        do_tick();
        n_checks++;
        if (cur() !== hms(23, 59, 59)) begin
            n_errors++;
            $display("FAIL pre_rollover: got %0d:%0d:%0d want 23:59:59", sw.o_hr, sw.o_min, sw.o_sec);
        end
        do_tick();
`ifdef STOPWATCH_HR_WRAP_EN
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL hr_wrap: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(MS);
`else
        n_checks++;
        if (cur() !== hms(23, 59, 59)) begin
            n_errors++;
            $display("FAIL hr_saturate: got %0d:%0d:%0d want 23:59:59", sw.o_hr, sw.o_min, sw.o_sec);
        end
        ticks(MS);
        n_checks++;
        if (cur() !== hms(23, 59, 59)) begin
            n_errors++;
            $display("FAIL sat_held: got %0d:%0d:%0d want 23:59:59", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(0, 1, 0, 0);
        n_checks++;
        if (cur() !== hms(0, 0, 0)) begin
            n_errors++;
            $display("FAIL sat_clear: got %0d:%0d:%0d want 0:0:0", sw.o_hr, sw.o_min, sw.o_sec);
        end
        press(1, 0, 0, 0);
        ticks(MS);
`endif
        n_checks++;
        if (cur() !== hms(0, 0, 1)) begin
            n_errors++;
            $display("FAIL after_rollover: got %0d:%0d:%0d want 0:0:1", sw.o_hr, sw.o_min, sw.o_sec);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_idle();
        test_count();
        test_lap();
        test_pause();
        test_set();
        test_simultaneous();
        test_reset_midrun();
        test_rollover();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
